// File: rtl/mips_inst_encoder_if.sv
// Bus between the boot/test sequencer (master) and the instruction encoder (slave):
// symbolic instruction handshake, control pulses, memory write port and status.
interface mips_inst_encoder_if #(
    parameter int ADDR_W = 6
) ();
    logic              clr;
    logic              seal;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              sealed;
    logic              err;

    modport master (
        output clr, seal, in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, sealed, err
    );

    modport slave (
        input  clr, seal, in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, sealed, err
    );
endinterface

// File: rtl/mips_inst_encoder.sv
// Assembles symbolic MIPS instructions into machine words and streams them into
// consecutive instruction-memory words, optionally sealing the program with a halt loop.
module mips_inst_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    mips_inst_encoder_if.slave  bus
);
    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_FULL   = 2'd1;
    localparam logic [1:0] ST_SEALED = 2'd2;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        full;
    logic        sealed;
    logic        in_ready;
    logic        accept;
    logic        legal;
    logic [31:0] word;

    assign full     = (count_q == CAPACITY);
    assign sealed   = (state_q == ST_SEALED);
    assign in_ready = !full && !sealed && !bus.seal && !bus.clr && !rst;
    assign accept   = bus.in_valid && in_ready;

    // Unused fields of each format are dropped here so they never leak into the word.
    always_comb begin
        legal = 1'b1;
        word  = 32'd0;
        case (bus.in_op)
            5'd0:  word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100000};
            5'd1:  word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100010};
            5'd2:  word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100100};
            5'd3:  word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100101};
            5'd4:  word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100110};
            5'd5:  word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b100111};
            5'd6:  word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b101011};
            5'd7:  word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b000100};
            5'd8:  word = {6'b000000, bus.in_rs, 15'd0, 6'b001000};
            5'd9:  word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd10: word = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd11: word = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd12: word = {6'b001011, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd13: word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd14: word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd15: word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd16: word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
            5'd17: word = {6'b000010, bus.in_target};
            5'd18: word = {6'b000011, bus.in_target};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (bus.clr) begin
            state_d = ST_LOAD;
            count_d = '0;
            err_d   = 1'b0;
        end else if (bus.seal) begin
            if (state_q == ST_LOAD) begin
                // Halt loop: a jump whose target is its own word address.
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = {6'b000010, 26'(count_q)};
                count_d = count_q + CNT_ONE;
                state_d = ST_SEALED;
            end else if (state_q == ST_FULL) begin
                err_d = 1'b1;
            end
        end else if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = word;
                count_d = count_q + CNT_ONE;
                if (count_q + CNT_ONE == CAPACITY) begin
                    state_d = ST_FULL;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.sealed    = sealed;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mips_inst_encoder.sv
// Directed bench: a 64-word encoder for encoding/seal scenarios and a 4-word one for capacity limits.
module tb_mips_inst_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    mips_inst_encoder_if #(.ADDR_W(6)) a ();
    mips_inst_encoder_if #(.ADDR_W(2)) b ();

    mips_inst_encoder #(.ADDR_W(6)) dut_a (.clk(clk), .rst(rst), .bus(a));
    mips_inst_encoder #(.ADDR_W(2)) dut_b (.clk(clk), .rst(rst), .bus(b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] target);
        a.in_valid = 1'b1; a.in_op = op; a.in_rs = rs; a.in_rt = rt; a.in_rd = rd;
        a.in_imm = imm; a.in_target = target;
    endtask

    task automatic clr_a();
        a.in_valid = 1'b0; a.clr = 1'b1;
        tick();
        a.clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_total++; if (a.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b exp 0", a.in_ready); else n_pass++;
        n_total++; if (a.mem_we !== 1'b0 || a.mem_addr !== 6'd0 || a.mem_wdata !== 32'd0)
            $display("FAIL rst_mem: got we=%b addr=%0d data=%h exp 0/0/0", a.mem_we, a.mem_addr, a.mem_wdata); else n_pass++;
        n_total++; if (a.count !== 7'd0 || a.full !== 1'b0 || a.sealed !== 1'b0 || a.err !== 1'b0)
            $display("FAIL rst_status: got cnt=%0d full=%b sealed=%b err=%b exp 0/0/0/0", a.count, a.full, a.sealed, a.err); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (a.in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b exp 1", a.in_ready); else n_pass++;
    endtask

    task automatic test_single_add();
        drive_a(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        a.in_valid = 1'b0;
        $display("add: we=%b addr=%0d data=%h count=%0d", a.mem_we, a.mem_addr, a.mem_wdata, a.count);
        n_total++; if (a.mem_we !== 1'b1 || a.mem_addr !== 6'd0) $display("FAIL add_we_addr: got %b/%0d exp 1/0", a.mem_we, a.mem_addr); else n_pass++;
        n_total++; if (a.mem_wdata !== 32'h00221820) $display("FAIL add_wdata: got %h exp 00221820", a.mem_wdata); else n_pass++;
        n_total++; if (a.count !== 7'd1) $display("FAIL add_count: got %0d exp 1", a.count); else n_pass++;
        tick();
        n_total++; if (a.mem_we !== 1'b0) $display("FAIL add_we_one_cycle: got %b exp 0", a.mem_we); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clr_a();
        n_total++; if (a.count !== 7'd0 || a.mem_we !== 1'b0) $display("FAIL clr_count: got cnt=%0d we=%b exp 0/0", a.count, a.mem_we); else n_pass++;
        drive_a(5'd13, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0);
        tick();
        $display("lw: we=%b addr=%0d data=%h", a.mem_we, a.mem_addr, a.mem_wdata);
        n_total++; if (a.mem_we !== 1'b1 || a.mem_addr !== 6'd0 || a.mem_wdata !== 32'h8C080004)
            $display("FAIL b2b_lw: got %b/%0d/%h exp 1/0/8c080004", a.mem_we, a.mem_addr, a.mem_wdata); else n_pass++;
        drive_a(5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0);
        tick();
        $display("sllv: we=%b addr=%0d data=%h", a.mem_we, a.mem_addr, a.mem_wdata);
        n_total++; if (a.mem_we !== 1'b1 || a.mem_addr !== 6'd1 || a.mem_wdata !== 32'h00622004)
            $display("FAIL b2b_sllv: got %b/%0d/%h exp 1/1/00622004", a.mem_we, a.mem_addr, a.mem_wdata); else n_pass++;
        drive_a(5'd15, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        tick();
        a.in_valid = 1'b0;
        $display("beq: we=%b addr=%0d data=%h", a.mem_we, a.mem_addr, a.mem_wdata);
        n_total++; if (a.mem_we !== 1'b1 || a.mem_addr !== 6'd2 || a.mem_wdata !== 32'h1022FFFF)
            $display("FAIL b2b_beq: got %b/%0d/%h exp 1/2/1022ffff", a.mem_we, a.mem_addr, a.mem_wdata); else n_pass++;
        n_total++; if (a.count !== 7'd3) $display("FAIL b2b_count: got %0d exp 3", a.count); else n_pass++;
    endtask

    task automatic test_field_forcing();
        clr_a();
        drive_a(5'd17, 5'd7, 5'd0, 5'd0, 16'h0, 26'h10);
        tick();
        $display("j: data=%h", a.mem_wdata);
        n_total++; if (a.mem_wdata !== 32'h08000010) $display("FAIL j_word: got %h exp 08000010", a.mem_wdata); else n_pass++;
        drive_a(5'd18, 5'd7, 5'd0, 5'd0, 16'h0, 26'h10);
        tick();
        $display("jal: data=%h", a.mem_wdata);
        n_total++; if (a.mem_wdata !== 32'h0C000010) $display("FAIL jal_word: got %h exp 0c000010", a.mem_wdata); else n_pass++;
        drive_a(5'd8, 5'd5, 5'd6, 5'd7, 16'hABCD, 26'h3FFFFFF);
        tick();
        $display("jr: data=%h", a.mem_wdata);
        n_total++; if (a.mem_wdata !== 32'h00A00008) $display("FAIL jr_word: got %h exp 00a00008", a.mem_wdata); else n_pass++;
        drive_a(5'd9, 5'd1, 5'd2, 5'd9, 16'h1234, 26'h3FFFFFF);
        tick();
        a.in_valid = 1'b0;
        $display("addi: data=%h", a.mem_wdata);
        n_total++; if (a.mem_wdata !== 32'h20221234 || a.mem_addr !== 6'd3) $display("FAIL addi_word: got %h@%0d exp 20221234@3", a.mem_wdata, a.mem_addr); else n_pass++;
    endtask

    task automatic test_illegal();
        clr_a();
        drive_a(5'd25, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        $display("op25: we=%b count=%0d err=%b", a.mem_we, a.count, a.err);
        n_total++; if (a.mem_we !== 1'b0 || a.count !== 7'd0) $display("FAIL ill_nowrite: got we=%b cnt=%0d exp 0/0", a.mem_we, a.count); else n_pass++;
        n_total++; if (a.err !== 1'b1) $display("FAIL ill_err: got %b exp 1", a.err); else n_pass++;
        drive_a(5'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        tick();
        a.in_valid = 1'b0;
        n_total++; if (a.err !== 1'b1 || a.mem_wdata !== 32'h00221822 || a.count !== 7'd1)
            $display("FAIL ill_sticky: got err=%b data=%h cnt=%0d exp 1/00221822/1", a.err, a.mem_wdata, a.count); else n_pass++;
        clr_a();
        n_total++; if (a.err !== 1'b0) $display("FAIL ill_clr: got %b exp 0", a.err); else n_pass++;
    endtask

    task automatic test_seal();
        clr_a();
        for (int i = 0; i < 5; i++) begin
            drive_a(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
            tick();
        end
        a.seal = 1'b1;
        tick();
        a.seal = 1'b0;
        #1;
        $display("seal: we=%b addr=%0d data=%h sealed=%b count=%0d", a.mem_we, a.mem_addr, a.mem_wdata, a.sealed, a.count);
        n_total++; if (a.mem_we !== 1'b1 || a.mem_addr !== 6'd5 || a.mem_wdata !== 32'h08000005)
            $display("FAIL seal_write: got %b/%0d/%h exp 1/5/08000005", a.mem_we, a.mem_addr, a.mem_wdata); else n_pass++;
        n_total++; if (a.sealed !== 1'b1 || a.in_ready !== 1'b0 || a.count !== 7'd6)
            $display("FAIL seal_state: got sealed=%b rdy=%b cnt=%0d exp 1/0/6", a.sealed, a.in_ready, a.count); else n_pass++;
        tick();
        n_total++; if (a.mem_we !== 1'b0 || a.count !== 7'd6) $display("FAIL seal_no_accept: got we=%b cnt=%0d exp 0/6", a.mem_we, a.count); else n_pass++;
        a.in_valid = 1'b0; a.seal = 1'b1;
        tick();
        a.seal = 1'b0;
        n_total++; if (a.mem_we !== 1'b0 || a.err !== 1'b0) $display("FAIL seal_again: got we=%b err=%b exp 0/0", a.mem_we, a.err); else n_pass++;
    endtask

    task automatic test_full();
        b.in_op = 5'd2; b.in_rs = 5'd4; b.in_rt = 5'd5; b.in_rd = 5'd6;
        b.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("full_wr %0d: we=%b addr=%0d data=%h count=%0d", i, b.mem_we, b.mem_addr, b.mem_wdata, b.count);
            if (i == 2) begin
                n_total++; if (b.in_ready !== 1'b1 || b.count !== 3'd3) $display("FAIL full_near: got rdy=%b cnt=%0d exp 1/3", b.in_ready, b.count); else n_pass++;
            end
        end
        n_total++; if (b.mem_addr !== 2'd3 || b.mem_wdata !== 32'h00853024) $display("FAIL full_last: got %0d/%h exp 3/00853024", b.mem_addr, b.mem_wdata); else n_pass++;
        n_total++; if (b.full !== 1'b1 || b.in_ready !== 1'b0 || b.count !== 3'd4)
            $display("FAIL full_flag: got full=%b rdy=%b cnt=%0d exp 1/0/4", b.full, b.in_ready, b.count); else n_pass++;
        tick();
        b.in_valid = 1'b0;
        n_total++; if (b.mem_we !== 1'b0 || b.count !== 3'd4) $display("FAIL full_stall: got we=%b cnt=%0d exp 0/4", b.mem_we, b.count); else n_pass++;
        b.seal = 1'b1;
        tick();
        b.seal = 1'b0;
        n_total++; if (b.mem_we !== 1'b0 || b.err !== 1'b1 || b.sealed !== 1'b0)
            $display("FAIL full_seal: got we=%b err=%b sealed=%b exp 0/1/0", b.mem_we, b.err, b.sealed); else n_pass++;
        b.clr = 1'b1;
        tick();
        b.clr = 1'b0;
        #1;
        n_total++; if (b.count !== 3'd0 || b.full !== 1'b0 || b.err !== 1'b0 || b.in_ready !== 1'b1)
            $display("FAIL full_clr: got cnt=%0d full=%b err=%b rdy=%b exp 0/0/0/1", b.count, b.full, b.err, b.in_ready); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        clr_a();
        drive_a(5'd4, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        tick();
        a.in_valid = 1'b0;
        n_total++; if (a.mem_we !== 1'b1) $display("FAIL mid_pre: got we=%b exp 1", a.mem_we); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (a.mem_we !== 1'b0 || a.count !== 7'd0 || a.in_ready !== 1'b0)
            $display("FAIL mid_rst: got we=%b cnt=%0d rdy=%b exp 0/0/0", a.mem_we, a.count, a.in_ready); else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_total++; if (a.in_ready !== 1'b1) $display("FAIL mid_release: got rdy=%b exp 1", a.in_ready); else n_pass++;
    endtask

    initial begin
        a.clr = 1'b0; a.seal = 1'b0; a.in_valid = 1'b0; a.in_op = '0; a.in_rs = '0;
        a.in_rt = '0; a.in_rd = '0; a.in_imm = '0; a.in_target = '0;
        b.clr = 1'b0; b.seal = 1'b0; b.in_valid = 1'b0; b.in_op = '0; b.in_rs = '0;
        b.in_rt = '0; b.in_rd = '0; b.in_imm = '0; b.in_target = '0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_field_forcing();
        test_illegal();
        test_seal();
        test_full();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mips_inst_encoder.md
# mips_inst_encoder

Sequential MIPS instruction encoder and program loader: the inverse of the control decoder. It accepts one symbolic instruction per handshake (operation index plus register, immediate and target fields) and assembles the 32-bit machine word. It writes the word to consecutive instruction-memory locations and can seal the program with a halt loop. It sits between the test/boot sequencer and the instruction RAM write port.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity 2**ADDR_W words
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of pointer, err and sealed flags
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept this cycle
- in_op  in  5  operation index (mapping below)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target field
- seal  in  1  one-cycle pulse: append halt loop and stop
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address of the write
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/clr
- full  out  1  count == 2**ADDR_W
- sealed  out  1  halt loop written; no further accepts
- err  out  1  sticky: illegal op or seal when full

## Operation
- Op map (index: mnemonic, op/funct), R-type word = {6'b0,rs,rt,rd,5'b0,funct}: 0 add 100000, 1 sub 100010, 2 and 100100, 3 or 100101, 4 xor 100110, 5 nor 100111, 6 sltu 101011, 7 sllv 000100, 8 jr 001000 (rt, rd, shamt forced 0).
- I-type word = {op,rs,rt,imm}: 9 addi 001000, 10 andi 001100, 11 xori 001110, 12 sltiu 001011, 13 lw 100011, 14 sw 101011, 15 beq 000100, 16 bne 000101.
- J-type word = {op,target}: 17 j 000010, 18 jal 000011.
- Fields not used by a format are ignored and forced to zero in the word.
- Handshake: accept when in_valid && in_ready. in_ready = !full && !sealed && !seal && !clr && !rst.
- Accepted legal op: write at address count[ADDR_W-1:0]; count increments by 1.
- Accepted op index 19..31: word dropped, no write, count unchanged, err set.
- States: LOAD (accepting), FULL (count at capacity), SEALED. LOAD->FULL when count reaches 2**ADDR_W; LOAD->SEALED on seal; FULL->SEALED never; any state->LOAD on clr.
- seal in LOAD: writes j to itself, word {6'b000010, 26-bit zero-extended count}, at address count; count increments; sealed=1. seal has priority over a simultaneous in_valid (instruction not accepted).
- seal in FULL: no write, err set. seal in SEALED: ignored.
- clr: count=0, err=0, sealed=0, state LOAD; a write registered in the previous cycle still completes.

## Timing
- Reset values: in_ready 0 while rst high then 1, mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, sealed 0, err 0.
- Latency: mem_we/mem_addr/mem_wdata registered, asserted exactly one cycle after the accepting (or seal) edge, for one cycle.
- Throughput: one instruction per cycle, back-to-back, no bubbles.
- count, full, sealed, err update on the same edge that registers the write.
- Accept on the cycle count becomes 2**ADDR_W-1 is allowed; in_ready drops the following cycle.
- mem_addr wraps never: writes stop at full.
- rst mid-stream: any pending write is discarded (mem_we 0).

## Test plan
- add rd=3 rs=1 rt=2 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820, count=1.
- Back-to-back lw rt=8 rs=0 imm=4, sllv rd=4 rt=2 rs=3, beq rs=1 rt=2 imm=0xFFFF -> words 0x8C080004, 0x00622004, 0x1022FFFF at addresses 0,1,2 on three consecutive cycles.
- j target=0x10, jal target=0x10, in_rs=7 -> 0x08000010, 0x0C000010 (rs ignored).
- in_op=25 -> no mem_we, count unchanged, err=1 until clr.
- Five legal ops then seal together with in_valid -> write 0x08000005 at address 5, sealed=1, in_ready=0, the coincident instruction not accepted.
- ADDR_W=2: four accepts -> full=1, in_ready=0; seal -> err=1, no write; clr -> count=0, full=0, err=0, in_ready=1.
